bit_reverse_stream: RTL and testbench

Parametrised, streaming successor to the combinational bit reverser. It accepts words over a valid/ready handshake and applies one of four per-word permutations: pass, full bit reverse, byte swap, or bit reverse within each byte. Results are buffered in an internal FIFO of configurable depth. It sits between a producer and consumer that both use valid/ready, so downstream backpressure no longer stalls the permutation logic word-by-word.

---
 rtl/bit_reverse_stream_if.sv | 27 ++
 rtl/bit_reverse_stream.sv | 93 +++++++++
 tb/tb_bit_reverse_stream.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/bit_reverse_stream_if.sv
// Valid/ready stream bundle for bit_reverse_stream: producer side, consumer side and occupancy.
// The slave modport is the block's view. The master modport is the view of the environment driving it.
interface bit_reverse_stream_if #(
    parameter int DATA_WIDTH = 16,
    parameter int DEPTH      = 4
);
    localparam int LW = $clog2(DEPTH) + 1;

    logic                  in_valid;
    logic                  in_ready;
    logic [DATA_WIDTH-1:0] in_data;
    logic [1:0]            in_mode;
    logic                  out_valid;
    logic                  out_ready;
    logic [DATA_WIDTH-1:0] out_data;
    logic [LW-1:0]         level;

    modport slave (
        input  in_valid, in_data, in_mode, out_ready,
        output in_ready, out_valid, out_data, level
    );

    modport master (
        output in_valid, in_data, in_mode, out_ready,
        input  in_ready, out_valid, out_data, level
    );
endinterface

// File: rtl/bit_reverse_stream.sv
// Streaming word permuter: pass / full bit reverse / byte swap / per-byte bit reverse,
// with results buffered in a first-word-fall-through FIFO.
module bit_reverse_stream #(
    parameter int DATA_WIDTH = 16,
    parameter int DEPTH      = 4,
    localparam int LW        = $clog2(DEPTH) + 1
) (
    input  logic                   clk,
    input  logic                   rst,
    bit_reverse_stream_if.slave    bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int NB = DATA_WIDTH / 8;

    logic [DATA_WIDTH-1:0] rev_w, swp_w, brv_w, perm_w;

    for (genvar b = 0; b < DATA_WIDTH; b++) begin : g_rev
        assign rev_w[b] = bus.in_data[DATA_WIDTH-1-b];
    end

    for (genvar k = 0; k < NB; k++) begin : g_byte
        assign swp_w[8*k +: 8] = bus.in_data[8*(NB-1-k) +: 8];
        for (genvar j = 0; j < 8; j++) begin : g_bit
            assign brv_w[8*k+j] = bus.in_data[8*k+7-j];
        end
    end

    always_comb begin
        perm_w = bus.in_data;
        case (bus.in_mode)
            2'b01:   perm_w = rev_w;
            2'b10:   perm_w = swp_w;
            2'b11:   perm_w = brv_w;
            default: perm_w = bus.in_data;
        endcase
    end

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]         wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, rd_next_w;
    logic [LW-1:0]         level_q, level_d;
    logic [DATA_WIDTH-1:0] head_q, head_d;
    logic                  in_ready_w, push_w, pop_w;

    assign in_ready_w = (level_q != LW'(DEPTH)) && !rst;
    assign push_w     = bus.in_valid && in_ready_w;
    assign pop_w      = (level_q != '0) && bus.out_ready;
    assign rd_next_w  = rd_ptr_q + PW'(1);

    // head_q mirrors the FIFO head so out_data is registered and holds its last value when empty.
    always_comb begin
        wr_ptr_d = push_w ? wr_ptr_q + PW'(1) : wr_ptr_q;
        rd_ptr_d = pop_w ? rd_next_w : rd_ptr_q;
        level_d  = level_q;
        if (push_w && !pop_w)
            level_d = level_q + LW'(1);
        else if (pop_w && !push_w)
            level_d = level_q - LW'(1);
        head_d = head_q;
        if (level_q == '0) begin
            if (push_w)
                head_d = perm_w;
        end else if (pop_w) begin
            if (level_q > LW'(1))
                head_d = mem_q[rd_next_w];
            else if (push_w)
                head_d = perm_w;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            head_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            head_q   <= head_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_w)
            mem_q[wr_ptr_q] <= perm_w;
    end

    assign bus.in_ready  = in_ready_w;
    assign bus.out_valid = (level_q != '0);
    assign bus.out_data  = head_q;
    assign bus.level     = level_q;
endmodule

// File: tb/tb_bit_reverse_stream.sv
// Random and directed stimulus for bit_reverse_stream, checked against a queue-based reference model.
module tb_bit_reverse_stream;
    localparam int DW    = 16;
    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    bit_reverse_stream_if #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) bus ();
    bit_reverse_stream_if #(.DATA_WIDTH(8),  .DEPTH(DEPTH)) bus8 ();

    bit_reverse_stream #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    bit_reverse_stream #(.DATA_WIDTH(8), .DEPTH(DEPTH)) dut8 (
        .clk (clk),
        .rst (rst),
        .bus (bus8.slave)
    );

    int n_chk  = 0;
    int n_fail = 0;

    logic [DW-1:0] q[$];
    logic [DW-1:0] hold = '0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [DW-1:0] perm(input logic [DW-1:0] d, input logic [1:0] m);
        logic [DW-1:0] r, s;
        r = {<<{d}};
        s = {<<8{d}};
        case (m)
            2'b01:   return r;
            2'b10:   return s;
            2'b11:   return {<<8{r}};
            default: return d;
        endcase
    endfunction

    // One cycle: check outputs against the model, drive inputs, then advance the model past the edge.
    task automatic step(input logic iv, input logic [DW-1:0] d, input logic [1:0] m,
                        input logic ordy, input logic r);
        logic acc, pp;
        @(negedge clk);
        chk("level", 32'(bus.level), 32'(q.size()));
        chk("in_ready", 32'(bus.in_ready), 32'(!rst && q.size() != DEPTH));
        chk("out_valid", 32'(bus.out_valid), 32'(q.size() != 0));
        chk("out_data", 32'(bus.out_data), 32'((q.size() != 0) ? q[0] : hold));
        bus.in_valid  = iv;
        bus.in_data   = d;
        bus.in_mode   = m;
        bus.out_ready = ordy;
        rst           = r;
        acc = iv && !r && (q.size() < DEPTH);
        pp  = ordy && (q.size() > 0);
        @(posedge clk);
        if (r) begin
            q.delete();
            hold = '0;
        end else begin
            if (pp) begin
                hold = q[0];
                void'(q.pop_front());
            end
            if (acc)
                q.push_back(perm(d, m));
        end
    endtask

    initial begin
        bus.in_valid   = 1'b0;
        bus.in_data    = '0;
        bus.in_mode    = '0;
        bus.out_ready  = 1'b0;
        bus8.in_valid  = 1'b0;
        bus8.in_data   = '0;
        bus8.in_mode   = '0;
        bus8.out_ready = 1'b1;
        repeat (2) @(posedge clk);

        // Reset then idle
        for (int i = 0; i < 4; i++) step(1'b0, '0, 2'b00, 1'b0, 1'b0);

        // Four modes back to back on 0x2701
        step(1'b1, 16'h2701, 2'b00, 1'b1, 1'b0);
        #1 chk("m00", 32'(bus.out_data), 32'h2701);
        step(1'b1, 16'h2701, 2'b01, 1'b1, 1'b0);
        #1 chk("m01", 32'(bus.out_data), 32'h80E4);
        step(1'b1, 16'h2701, 2'b10, 1'b1, 1'b0);
        #1 chk("m10", 32'(bus.out_data), 32'h0127);
        step(1'b1, 16'h2701, 2'b11, 1'b1, 1'b0);
        #1 chk("m11", 32'(bus.out_data), 32'hE480);
        step(1'b0, '0, 2'b00, 1'b1, 1'b0);

        // 8-bit instance, full bit reverse
        @(negedge clk);
        bus8.in_valid = 1'b1;
        bus8.in_mode  = 2'b01;
        bus8.in_data  = 8'b0010_0111;
        @(posedge clk);
        #1 chk("w8_a", 32'(bus8.out_data), 32'hE4);
        chk("w8_av", 32'(bus8.out_valid), 32'd1);
        bus8.in_data = 8'b0000_0001;
        @(posedge clk);
        #1 chk("w8_b", 32'(bus8.out_data), 32'h80);
        bus8.in_valid = 1'b0;

        // Fill to full, then a 5th offer while popping must be refused
        for (int i = 0; i < DEPTH; i++) step(1'b1, 16'(16'h1000 + i), 2'(i), 1'b0, 1'b0);
        @(negedge clk);
        chk("full_lvl", 32'(bus.level), 32'(DEPTH));
        chk("full_rdy", 32'(bus.in_ready), 32'd0);
        step(1'b1, 16'hBEEF, 2'b00, 1'b1, 1'b0);
        #1 chk("full_pop_lvl", 32'(bus.level), 32'(DEPTH - 1));
        for (int i = 0; i < DEPTH + 1; i++) step(1'b0, '0, 2'b00, 1'b1, 1'b0);

        // Level 2, simultaneous push/pop for 10 cycles
        for (int i = 0; i < 2; i++) step(1'b1, 16'($urandom), 2'($urandom), 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) step(1'b1, 16'($urandom), 2'($urandom), 1'b1, 1'b0);
        #1 chk("lvl2_hold", 32'(bus.level), 32'd2);
        for (int i = 0; i < 3; i++) step(1'b0, '0, 2'b00, 1'b1, 1'b0);

        // Reset with 3 words buffered, then a lone word
        for (int i = 0; i < 3; i++) step(1'b1, 16'($urandom), 2'($urandom), 1'b0, 1'b0);
        step(1'b0, '0, 2'b00, 1'b0, 1'b1);
        #1 chk("rst_lvl", 32'(bus.level), 32'd0);
        chk("rst_data", 32'(bus.out_data), 32'd0);
        step(1'b1, 16'hA5C3, 2'b10, 1'b0, 1'b0);
        #1 chk("post_rst", 32'(bus.out_data), 32'hC3A5);
        for (int i = 0; i < 3; i++) step(1'b0, '0, 2'b00, 1'b1, 1'b0);

        // Random traffic with occasional reset
        for (int i = 0; i < 500; i++)
            step(($urandom % 4) != 0, 16'($urandom), 2'($urandom), ($urandom % 3) != 0,
                 ($urandom % 100) == 0);
        for (int i = 0; i < DEPTH + 2; i++) step(1'b0, '0, 2'b00, 1'b1, 1'b0);

        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end
endmodule
